serial_tx_frame: RTL and testbench

Parametrised, framed serial transmitter: the successor to the team's fixed 8-bit, data-only shifter. It accepts a DATA_W-bit word on a start/busy/done handshake and serialises it as a complete line frame: start bit, data bits in a configurable order, an optional parity bit, and one or two stop bits. Each symbol is held for exactly CLKS_PER_BIT clocks. The block sits between the register/control logic and the serial line pin.

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_bit_timer.sv | 29 ++
 rtl/serial_tx_frame.sv | 148 ++++++++++++++
 tb/tb_serial_tx_frame.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial transmitter and the planned receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } serial_tx_state_t;

  localparam logic TX_IDLE_LEVEL  = 1'b1;
  localparam logic TX_START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_bit_timer.sv
// Symbol-period counter: sym_end marks the last clock of every CLKS_PER_BIT-long symbol.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic sym_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign sym_end = (cnt_q == LAST);

  // Reloads at every symbol boundary, so it never wraps mid-symbol.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || sym_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_tx_frame.sv
// Framed serial transmitter: start bit, DATA_W data bits, optional parity, 1-2 stop bits.
// Optional parity symbol and parity_odd port are built when SERIAL_TX_FRAME_PARITY_EN is defined.
module serial_tx_frame
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
`ifdef SERIAL_TX_FRAME_PARITY_EN
  input  logic              parity_odd,
`endif
  output logic              tx,
  output logic              busy,
  output logic              done,
  output serial_tx_state_t  dbg_state
);

  // Handshake: start is accepted on any edge where the FSM is IDLE; busy is high
  // for the whole frame, done pulses for one cycle after it, and start seen while
  // busy is dropped (no queueing).
  localparam int BW = $clog2(DATA_W + 1);

  serial_tx_state_t  state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_next;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic              next_bit, sym_end;
`ifdef SERIAL_TX_FRAME_PARITY_EN
  logic              par_q, par_d;
`endif

  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == IDLE),
    .sym_end (sym_end)
  );

  always_comb begin
    next_bit   = (MSB_FIRST != 0) ? shift_q[DATA_W-1] : shift_q[0];
    shift_next = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SERIAL_TX_FRAME_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d   = START;
        shift_d   = data_in;
        bit_cnt_d = '0;
        tx_d      = TX_START_LEVEL;
        busy_d    = 1'b1;
`ifdef SERIAL_TX_FRAME_PARITY_EN
        par_d     = (^data_in) ^ parity_odd;
`endif
      end
      START: if (sym_end) begin
        state_d   = DATA;
        tx_d      = next_bit;
        shift_d   = shift_next;
        bit_cnt_d = BW'(1);
      end
      // bit_cnt_q counts data bits already put on the line.
      DATA: if (sym_end) begin
        if (bit_cnt_q == BW'(DATA_W)) begin
          bit_cnt_d = '0;
`ifdef SERIAL_TX_FRAME_PARITY_EN
          state_d   = PARITY;
          tx_d      = par_q;
`else
          state_d   = STOP;
          tx_d      = TX_IDLE_LEVEL;
`endif
        end else begin
          tx_d      = next_bit;
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
`ifdef SERIAL_TX_FRAME_PARITY_EN
      PARITY: if (sym_end) begin
        state_d = STOP;
        tx_d    = TX_IDLE_LEVEL;
      end
`endif
      // bit_cnt_q is reused to count stop symbols.
      STOP: if (sym_end) begin
        if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = TX_IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= TX_IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_FRAME_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SERIAL_TX_FRAME_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Directed bench for serial_tx_frame: three instances covering LSB/MSB order, 1/2 stop bits.
module tb_serial_tx_frame;
  import serial_pkg::*;

`ifdef SERIAL_TX_FRAME_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
  logic [7:0] a_data = '0, b_data = '0, c_data = '0;
`ifdef SERIAL_TX_FRAME_PARITY_EN
  logic a_po = 1'b0;
`endif
  logic a_tx, a_busy, a_done, b_tx, b_busy, b_done, c_tx, c_busy, c_done;
  serial_tx_state_t a_state, b_state, c_state;

  serial_tx_frame #(.CLKS_PER_BIT(4), .DATA_W(8), .STOP_BITS(1), .MSB_FIRST(0)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .data_in(a_data),
`ifdef SERIAL_TX_FRAME_PARITY_EN
    .parity_odd(a_po),
`endif
    .tx(a_tx), .busy(a_busy), .done(a_done), .dbg_state(a_state));

  serial_tx_frame #(.CLKS_PER_BIT(2), .DATA_W(8), .STOP_BITS(1), .MSB_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .data_in(b_data),
`ifdef SERIAL_TX_FRAME_PARITY_EN
    .parity_odd(1'b0),
`endif
    .tx(b_tx), .busy(b_busy), .done(b_done), .dbg_state(b_state));

  serial_tx_frame #(.CLKS_PER_BIT(4), .DATA_W(8), .STOP_BITS(2), .MSB_FIRST(0)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .data_in(c_data),
`ifdef SERIAL_TX_FRAME_PARITY_EN
    .parity_odd(1'b0),
`endif
    .tx(c_tx), .busy(c_busy), .done(c_done), .dbg_state(c_state));

  int c_done_cnt = 0;
  always @(negedge clk) if (c_done) c_done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after the accepting edge; syms bit i = symbol i.
  task automatic frame_a(input string tag, input logic [15:0] syms, input int pulse_at);
    int nsym = 1 + 8 + P + 1;
    for (int c = 0; c < nsym * 4; c++) begin
      check({tag, "_tx"}, a_tx, syms[c / 4]);
      check({tag, "_busy"}, a_busy, 1);
      check({tag, "_done_early"}, a_done, 0);
      a_start = (c == pulse_at);
      tick();
    end
    a_start = 1'b0;
    check({tag, "_done"}, a_done, 1);
    check({tag, "_busy_end"}, a_busy, 0);
    check({tag, "_tx_end"}, a_tx, 1);
    check({tag, "_state_end"}, a_state, IDLE);
    tick();
    check({tag, "_done_one"}, a_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsym_b, nsym_c, stop_high, stray;
    nsym_b = 1 + 8 + P + 1;
    nsym_c = 1 + 8 + P + 2;

    // reset state
    tick(); tick();
    check("rst_a_tx", a_tx, 1);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_state", a_state, IDLE);
    check("rst_b_tx", b_tx, 1);
    check("rst_c_busy", c_busy, 0);
    check("rst_c_state", c_state, IDLE);
    rst = 1'b0;
    tick();

    // basic frame 0xA5, data_in changed right after capture
    a_data = 8'hA5; a_start = 1'b1;
    tick();
    a_start = 1'b0; a_data = 8'h5A;
    frame_a("basic", (P != 0) ? 16'h054A : 16'h034A, -1);

    // start pulsed mid-frame is ignored
    a_data = 8'h3C; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    frame_a("ign_start", (P != 0) ? 16'h0478 : 16'h0278, 10);
    repeat (3) tick();
    check("ign_idle_busy", a_busy, 0);

`ifdef SERIAL_TX_FRAME_PARITY_EN
    // odd parity sense flips the parity symbol
    a_data = 8'hA5; a_po = 1'b1; a_start = 1'b1;
    tick();
    a_start = 1'b0; a_po = 1'b0;
    frame_a("par_odd", 16'h074A, -1);
`endif

    // MSB first, CLKS_PER_BIT = 2
    b_data = 8'h80; b_start = 1'b1;
    tick();
    b_start = 1'b0; b_data = 8'h01;
    for (int c = 0; c < nsym_b * 2; c++) begin
      check("msb_tx", b_tx, ((P != 0) ? 16'h0602 : 16'h0202) >> (c / 2) & 16'h1);
      check("msb_busy", b_busy, 1);
      tick();
    end
    check("msb_done", b_done, 1);
    check("msb_tx_end", b_tx, 1);

    // two stop bits, start held high: back-to-back 0x00 then 0xFF
    c_data = 8'h00; c_start = 1'b1;
    tick();
    c_data = 8'hFF;
    stop_high = 0;
    for (int c = 0; c < nsym_c * 4; c++) begin
      check("b2b1_tx", c_tx, ((P != 0) ? 16'h0C00 : 16'h0600) >> (c / 4) & 16'h1);
      check("b2b1_busy", c_busy, 1);
      if (c_tx) stop_high++;
      tick();
    end
    check("b2b1_stop_cycles", stop_high, 8);
    check("b2b1_done", c_done, 1);
    check("b2b1_busy_end", c_busy, 0);
    tick();
    for (int c = 0; c < nsym_c * 4; c++) begin
      check("b2b2_tx", c_tx, ((P != 0) ? 16'h0DFE : 16'h07FE) >> (c / 4) & 16'h1);
      check("b2b2_busy", c_busy, 1);
      c_start = 1'b0;
      tick();
    end
    check("b2b2_done", c_done, 1);
    tick();
    check("b2b2_done_one", c_done, 0);
    check("b2b_idle_busy", c_busy, 0);
    check("b2b_done_pulses", c_done_cnt, 2);

    // reset during data bit 3 of 0xA5
    a_data = 8'hA5; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (18) tick();
    check("mid_bit3_tx", a_tx, 0);
    rst = 1'b1;
    tick();
    check("mid_rst_tx", a_tx, 1);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_done", a_done, 0);
    check("mid_rst_state", a_state, IDLE);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 50; c++) begin
      if (a_done || a_busy) stray++;
      tick();
    end
    check("mid_no_done", stray, 0);
    a_data = 8'h3C; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    frame_a("after_rst", (P != 0) ? 16'h0478 : 16'h0278, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
